// File: rtl/data_memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// definitions / data_memory_arbiter_if
//
// definitions          : shared width constants for the data-memory path.
// data_memory_arbiter_if : bundles both requester ports and the data-memory
//                          port of the arbiter.
//
//   Requester side (driven by requesters, observed by arbiter):
//     _req0/_req1           access request
//     _write0/_write1       1 = write, 0 = read
//     _address0/_address1   target address
//     _valueIn0/_valueIn1   write data
//   Requester side (driven by arbiter):
//     grant0/grant1         one-cycle pulse, access in progress this cycle
//     rvalid0/rvalid1       one-cycle pulse, rdata valid (reads only)
//     rdata0/rdata1         registered read data, held until next read
//     busy                  arbiter is in ACCESS or DONE
//   Memory side:
//     memRead/memWrite      strobes (driven by arbiter)
//     memAddress/memValueIn address and write data (driven by arbiter)
//     _memValueOut          combinational read data (driven by memory)
//
// Modports: slave = the arbiter, master = requesters plus memory.
// -----------------------------------------------------------------------------
package definitions;
  parameter int DATA_WIDTH = 8;
endpackage : definitions

interface data_memory_arbiter_if #(
  parameter int W = definitions::DATA_WIDTH
);
  // Requester 0
  logic         _req0;
  logic         _write0;
  logic [W-1:0] _address0;
  logic [W-1:0] _valueIn0;
  logic         grant0;
  logic         rvalid0;
  logic [W-1:0] rdata0;

  // Requester 1
  logic         _req1;
  logic         _write1;
  logic [W-1:0] _address1;
  logic [W-1:0] _valueIn1;
  logic         grant1;
  logic         rvalid1;
  logic [W-1:0] rdata1;

  // Status
  logic         busy;

  // Data memory
  logic         memRead;
  logic         memWrite;
  logic [W-1:0] memAddress;
  logic [W-1:0] memValueIn;
  logic [W-1:0] _memValueOut;

  modport slave (
    input  _req0, _write0, _address0, _valueIn0,
    input  _req1, _write1, _address1, _valueIn1,
    input  _memValueOut,
    output grant0, rvalid0, rdata0,
    output grant1, rvalid1, rdata1,
    output busy,
    output memRead, memWrite, memAddress, memValueIn
  );

  modport master (
    output _req0, _write0, _address0, _valueIn0,
    output _req1, _write1, _address1, _valueIn1,
    output _memValueOut,
    input  grant0, rvalid0, rdata0,
    input  grant1, rvalid1, rdata1,
    input  busy,
    input  memRead, memWrite, memAddress, memValueIn
  );
endinterface : data_memory_arbiter_if

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Shares the single-port data memory between requester 0 (core load/store)
// and requester 1 (debug/loader). A request sampled in IDLE is latched, the
// memory is strobed for exactly one cycle (ACCESS), and read data is returned
// to the winner in the following cycle (DONE). Ties are broken by a priority
// bit that always points at the port that lost the most recent grant.
//
// Ports:
//   _CLK    clock, all state updates on posedge
//   _RST_N  asynchronous active-low reset
//   bus     data_memory_arbiter_if.slave (requester and memory signals)
//
// Every output is a flop, so nothing on the requester side reaches the memory
// combinationally.
// -----------------------------------------------------------------------------
module data_memory_arbiter (
  input  logic                  _CLK,
  input  logic                  _RST_N,
  data_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  logic   prio;     // port that wins a tie
  logic   port_q;   // port owning the current access
  logic   wr_q;     // current access is a write

  // Winner selection among the live requests in IDLE.
  logic win_port;
  logic win_write;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    win_port  = 1'b0;
    win_write = bus._write0;
    if (bus._req0 && bus._req1) begin
      win_port = prio;
    end else if (bus._req1) begin
      win_port = 1'b1;
    end
    if (win_port) begin
      win_write = bus._write1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // sees the pre-edge values of the others and ordering inside the block
  // does not matter.
  always_ff @(posedge _CLK or negedge _RST_N) begin
    if (!_RST_N) begin
      state          <= IDLE;
      prio           <= 1'b0;
      port_q         <= 1'b0;
      wr_q           <= 1'b0;
      bus.grant0     <= 1'b0;
      bus.grant1     <= 1'b0;
      bus.rvalid0    <= 1'b0;
      bus.rvalid1    <= 1'b0;
      bus.rdata0     <= '0;
      bus.rdata1     <= '0;
      bus.busy       <= 1'b0;
      bus.memRead    <= 1'b0;
      bus.memWrite   <= 1'b0;
      bus.memAddress <= '0;
      bus.memValueIn <= '0;
    end else begin
      // Pulsed outputs and memory lines are low unless a state sets them
      // for the next cycle.
      bus.grant0     <= 1'b0;
      bus.grant1     <= 1'b0;
      bus.rvalid0    <= 1'b0;
      bus.rvalid1    <= 1'b0;
      bus.memRead    <= 1'b0;
      bus.memWrite   <= 1'b0;
      bus.memAddress <= '0;
      bus.memValueIn <= '0;

      unique case (state)
        IDLE: begin
          if (bus._req0 || bus._req1) begin
            // The memory lines double as the latched address/data: they are
            // loaded here and are therefore valid for the whole ACCESS cycle.
            port_q         <= win_port;
            wr_q           <= win_write;
            bus.memAddress <= win_port ? bus._address1 : bus._address0;
            bus.memValueIn <= win_port ? bus._valueIn1 : bus._valueIn0;
            bus.memRead    <= ~win_write;
            bus.memWrite   <= win_write;
            bus.grant0     <= ~win_port;
            bus.grant1     <= win_port;
            bus.busy       <= 1'b1;
            state          <= ACCESS;
          end
        end

        ACCESS: begin
          // Memory data is combinational, so it is valid at this closing edge.
          if (!wr_q) begin
            if (port_q) begin
              bus.rdata1  <= bus._memValueOut;
              bus.rvalid1 <= 1'b1;
            end else begin
              bus.rdata0  <= bus._memValueOut;
              bus.rvalid0 <= 1'b1;
            end
          end
          prio  <= ~port_q;
          state <= DONE;
        end

        DONE: begin
          // Requests are deliberately not sampled here: the granted port
          // is still dropping its request at this point.
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule : data_memory_arbiter

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
//
// Directed bench for data_memory_arbiter with a behavioural single-port
// memory (combinational read, write on posedge while memWrite is high).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

  logic clk;
  logic rst_n;

  data_memory_arbiter_if bus ();

  data_memory_arbiter dut (
    ._CLK   (clk),
    ._RST_N (rst_n),
    .bus    (bus)
  );

  // Memory model, preloaded through a bench-side write port.
  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  assign bus._memValueOut = mem[bus.memAddress];

  always @(posedge clk) begin
    if (bus.memWrite) begin
      mem[bus.memAddress] <= bus.memValueIn;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " grant0"},     32'(bus.grant0),     32'h0);
    check({tag, " grant1"},     32'(bus.grant1),     32'h0);
    check({tag, " rvalid0"},    32'(bus.rvalid0),    32'h0);
    check({tag, " rvalid1"},    32'(bus.rvalid1),    32'h0);
    check({tag, " busy"},       32'(bus.busy),       32'h0);
    check({tag, " memRead"},    32'(bus.memRead),    32'h0);
    check({tag, " memWrite"},   32'(bus.memWrite),   32'h0);
    check({tag, " memAddress"}, 32'(bus.memAddress), 32'h0);
    check({tag, " memValueIn"}, 32'(bus.memValueIn), 32'h0);
    check({tag, " rdata0"},     32'(bus.rdata0),     32'h0);
    check({tag, " rdata1"},     32'(bus.rdata1),     32'h0);
  endtask

  initial begin
    rst_n         = 1'b0;
    pre_we        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;
    bus._req0     = 1'b0;
    bus._write0   = 1'b0;
    bus._address0 = '0;
    bus._valueIn0 = '0;
    bus._req1     = 1'b0;
    bus._write1   = 1'b0;
    bus._address1 = '0;
    bus._valueIn1 = '0;

    // ---------------- reset and memory preload ----------------
    preload(8'h00, 8'h00);
    preload(8'h10, 8'hA5);
    preload(8'h01, 8'h11);
    preload(8'h02, 8'h22);
    preload(8'h20, 8'h00);
    preload(8'h30, 8'h00);
    check_all_zero("reset");
    #3 rst_n = 1'b1;
    tick();
    check_all_zero("post-reset idle");

    // ---------------- single read, port 0 ----------------
    bus._req0 = 1'b1; bus._write0 = 1'b0; bus._address0 = 8'h10;
    tick();   // ACCESS
    check("rd grant0",     32'(bus.grant0),     32'h1);
    check("rd memRead",    32'(bus.memRead),    32'h1);
    check("rd memWrite",   32'(bus.memWrite),   32'h0);
    check("rd memAddress", 32'(bus.memAddress), 32'h10);
    check("rd busy1",      32'(bus.busy),       32'h1);
    bus._req0 = 1'b0;
    tick();   // DONE
    check("rd rvalid0",    32'(bus.rvalid0),    32'h1);
    check("rd rdata0",     32'(bus.rdata0),     32'hA5);
    check("rd grant0 off", 32'(bus.grant0),     32'h0);
    check("rd memRead off",32'(bus.memRead),    32'h0);
    check("rd addr off",   32'(bus.memAddress), 32'h0);
    check("rd busy2",      32'(bus.busy),       32'h1);
    tick();   // IDLE
    check("rd busy3",      32'(bus.busy),       32'h0);
    check("rd rvalid0 off",32'(bus.rvalid0),    32'h0);
    check("rd rdata0 hold",32'(bus.rdata0),     32'hA5);

    // ---------------- write then readback, port 1 ----------------
    bus._req1 = 1'b1; bus._write1 = 1'b1;
    bus._address1 = 8'h20; bus._valueIn1 = 8'h3C;
    tick();
    check("wr grant1",      32'(bus.grant1),     32'h1);
    check("wr memWrite",    32'(bus.memWrite),   32'h1);
    check("wr memRead",     32'(bus.memRead),    32'h0);
    check("wr memAddress",  32'(bus.memAddress), 32'h20);
    check("wr memValueIn",  32'(bus.memValueIn), 32'h3C);
    bus._req1 = 1'b0;
    tick();
    check("wr rvalid1",     32'(bus.rvalid1),    32'h0);
    check("wr memWrite off",32'(bus.memWrite),   32'h0);
    check("wr committed",   32'(mem[8'h20]),     32'h3C);
    tick();
    check("wr rvalid1 idle",32'(bus.rvalid1),    32'h0);
    bus._req1 = 1'b1; bus._write1 = 1'b0;
    tick();
    check("rb grant1",      32'(bus.grant1),     32'h1);
    check("rb memRead",     32'(bus.memRead),    32'h1);
    bus._req1 = 1'b0;
    tick();
    check("rb rvalid1",     32'(bus.rvalid1),    32'h1);
    check("rb rdata1",      32'(bus.rdata1),     32'h3C);
    check("rb rdata0 kept", 32'(bus.rdata0),     32'hA5);
    tick();

    // ---------------- contention after reset ----------------
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    bus._req0 = 1'b1; bus._write0 = 1'b0; bus._address0 = 8'h01;
    bus._req1 = 1'b1; bus._write1 = 1'b0; bus._address1 = 8'h02;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("cont grant0 c%0d", i), 32'(bus.grant0),
            32'((i == 0) || (i == 6)));
      check($sformatf("cont grant1 c%0d", i), 32'(bus.grant1),
            32'((i == 3) || (i == 9)));
      check($sformatf("cont exclusive c%0d", i),
            32'(bus.grant0 & bus.grant1), 32'h0);
      if (i == 1) check("cont rdata0", 32'(bus.rdata0), 32'h11);
      if (i == 4) check("cont rdata1", 32'(bus.rdata1), 32'h22);
    end
    bus._req0 = 1'b0;
    bus._req1 = 1'b0;
    tick();
    check("cont drained", 32'(bus.busy), 32'h0);

    // ---------------- priority carry-over ----------------
    bus._req1 = 1'b1; bus._write1 = 1'b0; bus._address1 = 8'h02;
    tick();
    check("carry grant1 alone", 32'(bus.grant1), 32'h1);
    bus._req1 = 1'b0;
    tick();
    tick();
    bus._req0 = 1'b1; bus._address0 = 8'h01;
    bus._req1 = 1'b1; bus._address1 = 8'h02;
    tick();
    check("carry tie grant0", 32'(bus.grant0), 32'h1);
    check("carry tie grant1", 32'(bus.grant1), 32'h0);
    bus._req0 = 1'b0;
    bus._req1 = 1'b0;
    tick();
    tick();

    // ---------------- reset mid-write ----------------
    bus._req1 = 1'b1; bus._write1 = 1'b1;
    bus._address1 = 8'h30; bus._valueIn1 = 8'hFF;
    tick();
    check("rstw grant1",   32'(bus.grant1),   32'h1);
    check("rstw memWrite", 32'(bus.memWrite), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rstw in reset");
    bus._req1 = 1'b0;
    bus._write1 = 1'b0;
    tick();
    check("rstw mem intact", 32'(mem[8'h30]), 32'h00);
    check("rstw no rvalid",  32'(bus.rvalid1), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    bus._req0 = 1'b1; bus._write0 = 1'b0; bus._address0 = 8'h30;
    bus._req1 = 1'b1; bus._write1 = 1'b0; bus._address1 = 8'h02;
    tick();
    check("rstw first grant0", 32'(bus.grant0), 32'h1);
    check("rstw first grant1", 32'(bus.grant1), 32'h0);
    bus._req0 = 1'b0;
    tick();
    check("rstw read 0x30", 32'(bus.rdata0), 32'h00);
    tick();   // IDLE: port 1 still requesting
    tick();
    check("post grant1", 32'(bus.grant1), 32'h1);
    bus._req1 = 1'b0;
    tick();
    check("post rdata1", 32'(bus.rdata1), 32'h22);
    tick();

    // ---------------- withdrawn request ----------------
    bus._req0 = 1'b1; bus._write0 = 1'b0; bus._address0 = 8'h01;
    tick();
    check("wd grant0", 32'(bus.grant0), 32'h1);
    bus._req0 = 1'b0;
    bus._req1 = 1'b1; bus._write1 = 1'b1;
    bus._address1 = 8'h20; bus._valueIn1 = 8'h77;
    tick();   // DONE, port 1 pulse seen only here
    check("wd grant1 done",  32'(bus.grant1), 32'h0);
    check("wd rdata0",       32'(bus.rdata0), 32'h11);
    bus._req1 = 1'b0;
    tick();   // IDLE
    check("wd grant1 idle",  32'(bus.grant1),   32'h0);
    check("wd busy idle",    32'(bus.busy),     32'h0);
    tick();
    check("wd grant1 later", 32'(bus.grant1),   32'h0);
    check("wd no memWrite",  32'(bus.memWrite), 32'h0);
    check("wd no memRead",   32'(bus.memRead),  32'h0);
    check("wd rdata1 kept",  32'(bus.rdata1),   32'h22);
    check("wd mem 0x20",     32'(mem[8'h20]),   32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "time limit reached");
  end

endmodule : tb_data_memory_arbiter
